// File: rtl/qspi_sram_emu_if.sv
// Pin-side QSPI bus between a QSPI master and the qspi_sram_emu device model.
interface qspi_sram_emu_if;
  logic       sck;
  logic       ss_n;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic [3:0] sio_oe;

  modport master (
    output sck,
    output ss_n,
    output sio_in,
    input  sio_out,
    input  sio_oe
  );

  modport slave (
    input  sck,
    input  ss_n,
    input  sio_in,
    output sio_out,
    output sio_oe
  );
endinterface

// File: rtl/qspi_sram_emu.sv
// Clocked QSPI SRAM emulator: oversamples sck/ss_n/sio on clk, supports 1-bit and quad
// read/write, fast read, mode register and burst wrap. QSPI_SRAM_EMU_ERR_EN adds a sticky err.
module qspi_sram_emu #(
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned PAGE_BYTES  = 32,
  parameter int unsigned WAIT_CYCLES = 6,
  parameter int unsigned FAST_DUMMY  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  qspi_sram_emu_if.slave bus
`ifdef QSPI_SRAM_EMU_ERR_EN
  ,
  output logic           err
`endif
);

  localparam int unsigned MemBytes = 2 ** ADDR_BITS;
  localparam int unsigned Last     = SYNC_STAGES - 1;
  localparam logic [ADDR_BITS-1:0] PageMask = ADDR_BITS'(PAGE_BYTES - 1);
  localparam logic [7:0] FastLast = 8'(FAST_DUMMY - 1);
  localparam logic [7:0] WaitLast = 8'(WAIT_CYCLES - 1);

  localparam logic [7:0] CmdRead   = 8'h03;
  localparam logic [7:0] CmdWrite  = 8'h02;
  localparam logic [7:0] CmdFast   = 8'h0B;
  localparam logic [7:0] CmdQRead  = 8'hEB;
  localparam logic [7:0] CmdQWrite = 8'h38;
  localparam logic [7:0] CmdModeWr = 8'h01;
  localparam logic [7:0] CmdModeRd = 8'h05;

  typedef enum logic [3:0] {
    StIdle, StCmd, StAddr, StAddrQ, StDummy, StRead, StReadQ,
    StWrite, StWriteQ, StModeWr, StModeRd, StFail
  } state_e;

  // Synchronisers and edge detect; pure pipelines, so they are left out of reset so
  // that a reset with ss_n held low does not fake a chip-select edge.
  logic [SYNC_STAGES-1:0]      sck_sync, ss_sync;
  logic [SYNC_STAGES-1:0][3:0] sio_sync;
  logic                        sck_q, ss_q;

  always_ff @(posedge clk) begin
    sck_sync[0] <= bus.sck;
    ss_sync[0]  <= bus.ss_n;
    sio_sync[0] <= bus.sio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sck_sync[i] <= sck_sync[i-1];
      ss_sync[i]  <= ss_sync[i-1];
      sio_sync[i] <= sio_sync[i-1];
    end
    sck_q <= sck_sync[Last];
    ss_q  <= ss_sync[Last];
  end

  logic       sck_rise, sck_fall, ss_hi, ss_fall;
  logic [3:0] din;

  assign sck_rise = sck_sync[Last] & ~sck_q;
  assign sck_fall = ~sck_sync[Last] & sck_q;
  assign ss_hi    = ss_sync[Last];
  assign ss_fall  = ss_q & ~ss_sync[Last];
  assign din      = sio_sync[Last];

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d, cnt_inc;
  logic [7:0]             cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rd_q, rd_d;
  logic [7:0]             mode_q, mode_d;
  logic [3:0]             dout_q, dout_d;
  logic [3:0]             oe_q, oe_d;
  logic                   mem_we, fetch;
  logic [7:0]             mem [MemBytes];

  assign cnt_inc = cnt_q + 8'd1;

  function automatic logic [ADDR_BITS-1:0] addr_next(input logic [ADDR_BITS-1:0] a,
                                                     input logic [1:0] m);
    logic [ADDR_BITS-1:0] inc;
    inc = a + ADDR_BITS'(1);
    case (m)
      2'b00:   return a;
      2'b01:   return (a & ~PageMask) | (inc & PageMask);
      default: return inc;
    endcase
  endfunction

  function automatic state_e post_addr(input logic [7:0] c);
    case (c)
      CmdRead:   return StRead;
      CmdWrite:  return StWrite;
      CmdQWrite: return StWriteQ;
      CmdFast:   return (FAST_DUMMY == 0) ? StRead : StDummy;
      CmdQRead:  return (WAIT_CYCLES == 0) ? StReadQ : StDummy;
      default:   return StFail;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    mem_we  = 1'b0;
    fetch   = 1'b0;

    if (ss_hi) begin
      state_d = StIdle;
      cnt_d   = '0;
      oe_d    = '0;
      dout_d  = '0;
    end else if (ss_fall) begin
      state_d = StCmd;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StCmd: if (sck_rise) begin
          cmd_d = {cmd_q[6:0], din[0]};
          cnt_d = cnt_inc;
          if (cnt_q == 8'd7) begin
            cnt_d = '0;
            case (cmd_d)
              CmdRead, CmdWrite, CmdFast: state_d = StAddr;
              CmdQRead, CmdQWrite:        state_d = StAddrQ;
              CmdModeWr:                  state_d = StModeWr;
              CmdModeRd: begin
                state_d = StModeRd;
                rd_d    = mode_q;
              end
              default:                    state_d = StFail;
            endcase
          end
        end
        StAddr: if (sck_rise) begin
          addr_d = ADDR_BITS'({addr_q, din[0]});
          cnt_d  = cnt_inc;
          if (cnt_q == 8'd23) begin
            cnt_d   = '0;
            fetch   = 1'b1;
            state_d = post_addr(cmd_q);
          end
        end
        StAddrQ: if (sck_rise) begin
          addr_d = ADDR_BITS'({addr_q, din});
          cnt_d  = cnt_inc;
          if (cnt_q == 8'd5) begin
            cnt_d   = '0;
            fetch   = 1'b1;
            state_d = post_addr(cmd_q);
          end
        end
        StDummy: if (sck_rise) begin
          cnt_d = cnt_inc;
          if (cnt_q == ((cmd_q == CmdFast) ? FastLast : WaitLast)) begin
            cnt_d   = '0;
            state_d = (cmd_q == CmdQRead) ? StReadQ : StRead;
          end
        end
        StRead, StModeRd: if (sck_fall) begin
          dout_d = {2'b00, rd_q[7], 1'b0};
          oe_d   = 4'b0010;
          rd_d   = {rd_q[6:0], 1'b0};
          cnt_d  = cnt_inc;
          if (cnt_q == 8'd7) begin
            cnt_d = '0;
            if (state_q == StRead) begin
              addr_d = addr_next(addr_q, mode_q[7:6]);
              fetch  = 1'b1;
            end else begin
              rd_d = mode_q;
            end
          end
        end
        StReadQ: if (sck_fall) begin
          dout_d = rd_q[7:4];
          oe_d   = 4'b1111;
          rd_d   = {rd_q[3:0], 4'b0000};
          cnt_d  = cnt_inc;
          if (cnt_q == 8'd1) begin
            cnt_d  = '0;
            addr_d = addr_next(addr_q, mode_q[7:6]);
            fetch  = 1'b1;
          end
        end
        StWrite: if (sck_rise) begin
          shift_d = {shift_q[6:0], din[0]};
          cnt_d   = cnt_inc;
          if (cnt_q == 8'd7) begin
            cnt_d  = '0;
            mem_we = 1'b1;
            addr_d = addr_next(addr_q, mode_q[7:6]);
          end
        end
        StWriteQ: if (sck_rise) begin
          shift_d = {shift_q[3:0], din};
          cnt_d   = cnt_inc;
          if (cnt_q == 8'd1) begin
            cnt_d  = '0;
            mem_we = 1'b1;
            addr_d = addr_next(addr_q, mode_q[7:6]);
          end
        end
        // After eight bits the register is loaded; idling ignores the rest of the frame.
        StModeWr: if (sck_rise) begin
          shift_d = {shift_q[6:0], din[0]};
          cnt_d   = cnt_inc;
          if (cnt_q == 8'd7) begin
            cnt_d   = '0;
            mode_d  = shift_d;
            state_d = StIdle;
          end
        end
        StIdle, StFail: ;
        default: state_d = StIdle;
      endcase
    end

    if (fetch) rd_d = mem[addr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      rd_q    <= '0;
      mode_q  <= 8'h80;
      dout_q  <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      rd_q    <= rd_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
    end
  end

  // Memory is deliberately not reset; commits land at the pre-advance address.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[addr_q] <= shift_d;
  end

  assign bus.sio_out = dout_q;
  assign bus.sio_oe  = oe_q;

`ifdef QSPI_SRAM_EMU_ERR_EN
  logic ss_rise, partial, sck_evt_q, err_q;

  assign ss_rise = ss_hi & ~ss_q;
  assign partial = (cnt_q != 8'd0) &&
                   (state_q inside {StCmd, StAddr, StAddrQ, StWrite, StWriteQ, StModeWr});

  // An sck phase only one clk sample wide means sck is running too fast for clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      sck_evt_q <= 1'b0;
    end else begin
      sck_evt_q <= sck_rise | sck_fall;
      if ((state_d == StFail && state_q != StFail) || (ss_rise && partial) ||
          ((sck_rise | sck_fall) && sck_evt_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_qspi_sram_emu.sv
// Scoreboard bench for qspi_sram_emu: drives the QSPI pins as a slow master and compares
// read data against expected bytes queued when each read is issued.
module tb_qspi_sram_emu;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [3:0] oe_or, oe_and, pre_oe;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  qspi_sram_emu_if bus_if ();
`ifdef QSPI_SRAM_EMU_ERR_EN
  logic err;
`endif

  qspi_sram_emu #(
    .ADDR_BITS  (16),
    .PAGE_BYTES (32),
    .WAIT_CYCLES(6),
    .FAST_DUMMY (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
`ifdef QSPI_SRAM_EMU_ERR_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- pin-level stimulus ----------------
  task automatic xfer1(input logic b, output logic o);
    bus_if.sio_in = {3'b000, b};
    #HALF;
    o = bus_if.sio_out[1];
    oe_or  = oe_or | bus_if.sio_oe;
    oe_and = oe_and & bus_if.sio_oe;
    bus_if.sck = 1'b1;
    #HALF;
    bus_if.sck = 1'b0;
  endtask

  task automatic xferq(input logic [3:0] n, output logic [3:0] o);
    bus_if.sio_in = n;
    #HALF;
    o = bus_if.sio_out;
    oe_or  = oe_or | bus_if.sio_oe;
    oe_and = oe_and & bus_if.sio_oe;
    bus_if.sck = 1'b1;
    #HALF;
    bus_if.sck = 1'b0;
  endtask

  task automatic clr_oe();
    oe_or  = 4'h0;
    oe_and = 4'hF;
  endtask

  task automatic cs_low();
    bus_if.ss_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    bus_if.ss_n = 1'b1;
    #(4 * HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic o;
    for (int i = 7; i >= 0; i--) xfer1(b[i], o);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic o;
    for (int i = 23; i >= 0; i--) xfer1(a[i], o);
  endtask

  task automatic send_addr_q(input logic [23:0] a);
    logic [3:0] o;
    for (int i = 5; i >= 0; i--) xferq(a[i*4 +: 4], o);
  endtask

  // Write n bytes taken MSB-first from data[8*n-1:0].
  task automatic do_write(input logic [7:0] cmd, input logic [23:0] a,
                          input logic [23:0] data, input int n);
    logic [3:0] o;
    logic [7:0] b;
    cs_low();
    send_byte(cmd);
    if (cmd == 8'h38) send_addr_q(a);
    else send_addr(a);
    for (int k = 0; k < n; k++) begin
      b = data[8*(n-1-k) +: 8];
      if (cmd == 8'h38) begin
        xferq(b[7:4], o);
        xferq(b[3:0], o);
      end else begin
        send_byte(b);
      end
    end
    cs_high();
  endtask

  task automatic do_mode_wr(input logic [7:0] m);
    cs_low();
    send_byte(8'h01);
    send_byte(m);
    cs_high();
  endtask

  // Issues a read of n bytes; received bytes go to got_q, pre-data oe goes to pre_oe.
  task automatic do_read(input logic [7:0] cmd, input logic [23:0] a, input int n,
                         input logic keep_cs);
    logic       o;
    logic [3:0] q;
    logic [7:0] b;
    cs_low();
    clr_oe();
    send_byte(cmd);
    if (cmd == 8'hEB) begin
      send_addr_q(a);
      for (int i = 0; i < 6; i++) xferq(4'h0, q);
    end else if (cmd != 8'h05) begin
      send_addr(a);
      if (cmd == 8'h0B) for (int i = 0; i < 8; i++) xfer1(1'b0, o);
    end
    pre_oe = oe_or;
    clr_oe();
    for (int k = 0; k < n; k++) begin
      if (cmd == 8'hEB) begin
        xferq(4'h0, q);
        b[7:4] = q;
        xferq(4'h0, q);
        b[3:0] = q;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          xfer1(1'b0, o);
          b[i] = o;
        end
      end
      got_q.push_back(b);
    end
    if (!keep_cs) cs_high();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] got, want;
    bus_if.sck = 1'b0;
    bus_if.ss_n = 1'b1;
    bus_if.sio_in = 4'h0;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bus_if.sio_oe !== 4'h0) begin
      failures++;
      $display("FAIL reset_oe: got %h want 0", bus_if.sio_oe);
    end
    checks++;
    if (bus_if.sio_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_out: got %h want 0", bus_if.sio_out);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
`ifdef QSPI_SRAM_EMU_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %b want 0", err);
    end
`endif
    exp_q.push_back(8'h80);
    do_read(8'h05, 24'h0, 1, 1'b0);
    got = got_q.pop_front();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_mode: got %h want %h", got, want);
    end
  endtask

  task automatic test_single_rw();
    logic [7:0] got, want;
    do_write(8'h02, 24'h000010, 24'h00A55A, 2);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    do_read(8'h03, 24'h000010, 2, 1'b1);
    checks++;
    if (pre_oe !== 4'h0) begin
      failures++;
      $display("FAIL single_oe_pre: got %h want 0", pre_oe);
    end
    checks++;
    if (oe_or !== 4'b0010 || oe_and !== 4'b0010) begin
      failures++;
      $display("FAIL single_oe_data: got or=%h and=%h want 2", oe_or, oe_and);
    end
    cs_high();
    checks++;
    if (bus_if.sio_oe !== 4'h0) begin
      failures++;
      $display("FAIL single_oe_idle: got %h want 0", bus_if.sio_oe);
    end
    for (int k = 0; k < 2; k++) begin
      got = got_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL single_data%0d: got %h want %h", k, got, want);
      end
    end
    // upper address bits beyond ADDR_BITS are ignored
    exp_q.push_back(8'hA5);
    do_read(8'h03, 24'h120010, 1, 1'b0);
    got = got_q.pop_front();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL single_alias: got %h want %h", got, want);
    end
  endtask

  task automatic test_quad();
    logic [7:0] got, want;
    do_write(8'h38, 24'h0000FF, 24'h001234, 2);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    do_read(8'hEB, 24'h0000FF, 2, 1'b0);
    checks++;
    if (pre_oe !== 4'h0 || oe_or !== 4'hF || oe_and !== 4'hF) begin
      failures++;
      $display("FAIL quad_oe: got pre=%h or=%h and=%h want 0/f/f", pre_oe, oe_or, oe_and);
    end
    for (int k = 0; k < 2; k++) begin
      got = got_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL quad_data%0d: got %h want %h", k, got, want);
      end
    end
    exp_q.push_back(8'h34);
    do_read(8'h03, 24'h000100, 1, 1'b0);
    got = got_q.pop_front();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL quad_0100: got %h want %h", got, want);
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0] got, want;
    do_write(8'h02, 24'h00FFFF, 24'h007788, 2);
    exp_q.push_back(8'h88);
    do_read(8'h03, 24'h000000, 1, 1'b0);
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h88);
    do_read(8'h0B, 24'h00FFFF, 2, 1'b0);
    checks++;
    if (pre_oe !== 4'h0) begin
      failures++;
      $display("FAIL fast_oe_dummy: got %h want 0", pre_oe);
    end
    for (int k = 0; k < 3; k++) begin
      got = got_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL wrap_data%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_page();
    logic [7:0] got, want;
    do_write(8'h02, 24'h000020, 24'h0000C3, 1);
    do_mode_wr(8'h40);
    do_write(8'h02, 24'h00001E, 24'h1E1F20, 3);
    exp_q.push_back(8'h20);
    do_read(8'h03, 24'h000000, 1, 1'b0);
    exp_q.push_back(8'hC3);
    do_read(8'h03, 24'h000020, 1, 1'b0);
    exp_q.push_back(8'h1E);
    exp_q.push_back(8'h1F);
    exp_q.push_back(8'h20);
    do_read(8'h03, 24'h00001E, 3, 1'b0);
    exp_q.push_back(8'h40);
    do_read(8'h05, 24'h0, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      got = got_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL page_data%0d: got %h want %h", k, got, want);
      end
    end
    do_mode_wr(8'h80);
  endtask

  task automatic test_abort();
    logic       o;
    logic [7:0] got, want;
    do_write(8'h02, 24'h000201, 24'h000099, 1);
    cs_low();
    send_byte(8'h02);
    send_addr(24'h000200);
    send_byte(8'h11);
    for (int i = 7; i >= 4; i--) xfer1(1'b1, o);
    cs_high();
`ifdef QSPI_SRAM_EMU_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL abort_err: got %b want 1", err);
    end
`endif
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h99);
    do_read(8'h03, 24'h000200, 2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      got = got_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL abort_data%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_bad_cmd();
    logic       o;
    logic [7:0] got, want;
    cs_low();
    clr_oe();
    send_byte(8'h9F);
    for (int i = 0; i < 16; i++) xfer1(1'b1, o);
    checks++;
    if (oe_or !== 4'h0) begin
      failures++;
      $display("FAIL badcmd_oe: got %h want 0", oe_or);
    end
    cs_high();
`ifdef QSPI_SRAM_EMU_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL badcmd_err: got %b want 1", err);
    end
`endif
    exp_q.push_back(8'hA5);
    do_read(8'h03, 24'h000010, 1, 1'b0);
    got = got_q.pop_front();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL badcmd_recover: got %h want %h", got, want);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] q;
    logic [7:0] got, want;
    do_mode_wr(8'h00);
    exp_q.push_back(8'h12);
    do_read(8'hEB, 24'h0000FF, 1, 1'b1);
    xferq(4'h0, q);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus_if.sio_oe !== 4'h0 || bus_if.sio_out !== 4'h0) begin
      failures++;
      $display("FAIL rstmid_oe: got oe=%h out=%h want 0/0", bus_if.sio_oe, bus_if.sio_out);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus_if.sio_oe !== 4'h0) begin
      failures++;
      $display("FAIL rstmid_oe_hold: got %h want 0", bus_if.sio_oe);
    end
`ifdef QSPI_SRAM_EMU_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_err: got %b want 0", err);
    end
`endif
    cs_high();
    exp_q.push_back(8'h80);
    do_read(8'h05, 24'h0, 1, 1'b0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    do_read(8'h03, 24'h000010, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      got = got_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL rstmid_data%0d: got %h want %h", k, got, want);
      end
    end
  endtask

  initial begin
    clr_oe();
    pre_oe = 4'h0;
    test_reset();
    test_single_rw();
    test_quad();
    test_seq_wrap();
    test_page();
    test_abort();
    test_bad_cmd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
